// File: rtl/stopwatch_display_pkg.sv
// Shared constants and types for the MM:SS multiplexed seven-segment driver.
package stopwatch_display_pkg;

   // Digit slot: 0 = seconds units ... 3 = minutes tens
   typedef logic [1:0] digit_idx_t;

   localparam digit_idx_t DIG_SEC_U = 2'd0;
   localparam digit_idx_t DIG_SEC_T = 2'd1;
   localparam digit_idx_t DIG_MIN_U = 2'd2;
   localparam digit_idx_t DIG_MIN_T = 2'd3;

   // Active-low segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/stopwatch_display_bcd_to_seg.sv
// Combinational nibble to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
   import stopwatch_display_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   // Table lookup of the digit pattern
   always_comb begin
      seg_o = SEG_DASH;
      case (nib_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed MM:SS display driver with anode blanking guard,
// frame-aligned input snapshot, leading-zero blanking and a blinking colon.
module stopwatch_display
   import stopwatch_display_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYC    = 500,
   parameter int BLINK_FRAMES = 125
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic [16:1] BCD,
   input  logic        BLINK_EN,
   input  logic        LZ_BLANK,
   output logic [4:1]  AN,
   output logic [6:0]  SEG,
   output logic        DP
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int FW = $clog2(BLINK_FRAMES + 1);

   logic [PW-1:0] presc_q, presc_d;
   digit_idx_t    idx_q, idx_d;
   logic [15:0]   snap_q, snap_d;
   logic [FW-1:0] frm_q, frm_d;
   logic          phase_q, phase_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          tc, frame_end, blank, colon_on;
   logic [3:0]    nib;
   logic [6:0]    dec_seg;

   assign nib = snap_q[{idx_q, 2'b00} +: 4];

   bcd_to_seg u_dec (
      .nib_i (nib),
      .seg_o (dec_seg)
   );

   // Scan timing, snapshot and colon-phase next state
   always_comb begin
      tc        = (presc_q == PW'(REFRESH_DIV - 1));
      frame_end = tc && (idx_q == DIG_MIN_T);
      presc_d   = tc ? '0 : presc_q + 1'b1;
      idx_d     = tc ? idx_q + 2'd1 : idx_q;
      // Only reload at the frame boundary so one frame never mixes two values
      snap_d    = frame_end ? BCD : snap_q;
      frm_d     = frm_q;
      phase_d   = phase_q;
      if (!BLINK_EN) begin
         frm_d   = '0;
         phase_d = 1'b1;
      end else if (frame_end) begin
         if (frm_q == FW'(BLINK_FRAMES - 1)) begin
            frm_d   = '0;
            phase_d = ~phase_q;
         end else begin
            frm_d = frm_q + 1'b1;
         end
      end
   end

   // Output pattern for the current slot; registered below
   always_comb begin
      blank    = (presc_q < PW'(BLANK_CYC));
      // BLINK_EN low must show the colon immediately, not a cycle later
      colon_on = phase_q | ~BLINK_EN;
      an_d     = 4'hF;
      seg_d    = SEG_BLANK;
      dp_d     = 1'b1;
      if (!blank) begin
         an_d = ~(4'b0001 << idx_q);
         if (LZ_BLANK && (idx_q == DIG_MIN_T) && (nib == 4'd0))
            seg_d = SEG_BLANK;
         else
            seg_d = dec_seg;
         dp_d = ~((idx_q == DIG_MIN_U) && colon_on);
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (RESET) begin
         presc_q <= '0;
         idx_q   <= DIG_SEC_U;
         snap_q  <= '0;
         frm_q   <= '0;
         phase_q <= 1'b1;
         an_q    <= 4'hF;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         frm_q   <= frm_d;
         phase_q <= phase_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign AN  = an_q;
   assign SEG = seg_q;
   assign DP  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display: cycle-accurate arithmetic model,
// directed vector table, hand-written corner sequences and random stimulus.
module tb_stopwatch_display;

   localparam int R  = 4;
   localparam int BC = 1;
   localparam int BF = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:1] bcd;
   logic        blink, lz;
   logic [4:1]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: cycles since reset, frames elapsed while blinking, displayed value
   int          m_n;
   int          m_run;
   logic [15:0] m_snap;
   logic [6:0]  segtab [16];

   stopwatch_display #(.REFRESH_DIV(R), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
      .clk      (clk),
      .RESET    (rst),
      .BCD      (bcd),
      .BLINK_EN (blink),
      .LZ_BLANK (lz),
      .AN       (an),
      .SEG      (seg),
      .DP       (dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // One clock: predict, clock, compare, then advance the model
   task automatic step();
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic [3:0] nib;
      int p, s;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      p = m_n % R;
      s = (m_n / R) % 4;
      if (!rst && p >= BC) begin
         nib   = 4'((m_snap >> (4 * s)) & 16'hF);
         e_an  = 4'hF & ~(4'(1 << s));
         e_seg = (lz && s == 3 && nib == 0) ? 7'h7F : segtab[nib];
         e_dp  = !(s == 2 && (!blink || ((m_run / BF) % 2 == 0)));
      end
      @(posedge clk); #1;
      chk("model_an", 16'(an), 16'(e_an));
      chk("model_seg", 16'(seg), 16'(e_seg));
      chk("model_dp", 16'(dp), 16'(e_dp));
      if (rst) begin
         m_n = 0; m_run = 0; m_snap = 16'h0;
      end else begin
         if (p == R - 1 && s == 3) begin
            m_snap = bcd;
            if (blink) m_run++;
         end
         if (!blink) m_run = 0;
         m_n++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Clock until the model reaches cycle k, then one more so outputs show state k
   task automatic at(input int k);
      int g = 0;
      while (m_n < k && g < 400) begin
         step();
         g++;
      end
      if (g >= 400) chk("at_timeout", 16'(g), 16'd0);
      step();
   endtask

   typedef struct {
      logic [15:0] bcd;
      logic        lz;
      int          slot;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dp;
   } vec_t;

   vec_t vecs[15];

   initial begin
      segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
                 7'b0111111};
      vecs[0]  = '{16'h1020, 1'b0, 0, 4'b1110, 7'b1000000, 1'b1};
      vecs[1]  = '{16'h1020, 1'b0, 1, 4'b1101, 7'b0100100, 1'b1};
      vecs[2]  = '{16'h1020, 1'b0, 2, 4'b1011, 7'b1000000, 1'b0};
      vecs[3]  = '{16'h1020, 1'b0, 3, 4'b0111, 7'b1111001, 1'b1};
      vecs[4]  = '{16'h0059, 1'b1, 3, 4'b0111, 7'b1111111, 1'b1};
      vecs[5]  = '{16'h0059, 1'b1, 2, 4'b1011, 7'b1000000, 1'b0};
      vecs[6]  = '{16'h0059, 1'b0, 3, 4'b0111, 7'b1000000, 1'b1};
      vecs[7]  = '{16'h0059, 1'b1, 0, 4'b1110, 7'b0010000, 1'b1};
      vecs[8]  = '{16'h0059, 1'b1, 1, 4'b1101, 7'b0010010, 1'b1};
      vecs[9]  = '{16'h00A0, 1'b0, 1, 4'b1101, 7'b0111111, 1'b1};
      vecs[10] = '{16'h00B7, 1'b0, 0, 4'b1110, 7'b1111000, 1'b1};
      vecs[11] = '{16'h3864, 1'b0, 0, 4'b1110, 7'b0011001, 1'b1};
      vecs[12] = '{16'h3864, 1'b0, 1, 4'b1101, 7'b0000010, 1'b1};
      vecs[13] = '{16'h3864, 1'b0, 2, 4'b1011, 7'b0000000, 1'b0};
      vecs[14] = '{16'h3864, 1'b1, 3, 4'b0111, 7'b0110000, 1'b1};

      m_n = 0; m_run = 0; m_snap = 16'h0;
      rst = 1'b1; bcd = 16'h0; blink = 1'b0; lz = 1'b0;

      // Reset state
      step();
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_seg", 16'(seg), 16'h7F);
      chk("rst_dp", 16'(dp), 16'h1);
      rst = 1'b0;
      step();
      chk("first_slot_blank_an", 16'(an), 16'hF);

      // Directed vectors, all displayed in the frame after the first boundary
      for (int i = 0; i < 15; i++) begin
         bcd = vecs[i].bcd; lz = vecs[i].lz; blink = 1'b0;
         do_reset();
         at(4 * R + R * vecs[i].slot + BC);
         chk($sformatf("vec%0d_an", i), 16'(an), 16'(vecs[i].an));
         chk($sformatf("vec%0d_seg", i), 16'(seg), 16'(vecs[i].seg));
         chk($sformatf("vec%0d_dp", i), 16'(dp), 16'(vecs[i].dp));
      end

      // Mid-frame BCD change only shows from the next frame
      bcd = 16'h1020; lz = 1'b0; blink = 1'b0;
      do_reset();
      at(4 * R + R * 1 + BC);
      bcd = 16'h4030;
      at(4 * R + R * 3 + BC);
      chk("midframe_old_mt", 16'(seg), 16'(7'b1111001));
      at(8 * R + R * 1 + BC);
      chk("midframe_new_st", 16'(seg), 16'(7'b0110000));
      at(8 * R + R * 3 + BC);
      chk("midframe_new_mt", 16'(seg), 16'(7'b0011001));

      // Colon blink: on for two frames, off for two
      bcd = 16'h1234; blink = 1'b1;
      do_reset();
      for (int f = 0; f < 8; f++) begin
         at(4 * R * f + 2 * R + BC);
         chk($sformatf("blink_f%0d_dp", f), 16'(dp), ((f / 2) % 2 == 0) ? 16'h0 : 16'h1);
      end

      // Reset mid index-2 slot restarts the scan at index 0 showing 0000
      blink = 1'b0;
      do_reset();
      at(4 * R + 2 * R + 2);
      rst = 1'b1;
      step();
      chk("midrst_an", 16'(an), 16'hF);
      chk("midrst_seg", 16'(seg), 16'h7F);
      rst = 1'b0;
      step();
      chk("post_rst_blank_an", 16'(an), 16'hF);
      at(BC);
      chk("post_rst_an", 16'(an), 16'b1110);
      chk("post_rst_seg", 16'(seg), 16'(7'b1000000));

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(7) == 0)   bcd = 16'($urandom);
         if ($urandom_range(15) == 0)  lz = ~lz;
         if ($urandom_range(40) == 0)  blink = ~blink;
         rst = ($urandom_range(299) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
